imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Instruction-memory responder: the memory end of the fetch interface. Accepts
//  word-aligned fetch requests, returns instruction words in request order
//  after a fixed read latency, and tolerates response backpressure via an
//  internal response FIFO. Sits beside fetch; a load port fills it before run.
// PARAMETERS
//  ADDR_W      32   request/load byte-address width
//  DATA_W      32   instruction word width
//  DEPTH_WORDS 256  memory size in words (power of 2, >=4)
//  READ_LAT    1    accept-to-FIFO-write cycles (1..3)
//  RSP_DEPTH   4    response FIFO depth (power of 2, >=2)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       asynchronous, active-low reset
//  req_valid  in   1       fetch request valid
//  req_ready  out  1       request accepted when valid&ready
//  req_addr   in   ADDR_W  byte address of requested instruction
//  rsp_valid  out  1       response word available
//  rsp_ready  in   1       consumer takes response when valid&ready
//  rsp_data   out  DATA_W  instruction word
//  rsp_err    out  1       request was misaligned or out of range
//  load_en    in   1       program-load write strobe
//  load_addr  in   ADDR_W  load byte address (bits [1:0] ignored)
//  load_data  in   DATA_W  load word
//  busy       out  1       any request in flight or response queued
// BEHAVIOUR
//  - Reset (rst=0, async): req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0,
//    busy=0; in-flight pipeline and FIFO flushed; credit count=0. Memory array
//    is NOT reset. Reset mid-operation drops all outstanding requests silently.
//  - Credits: inflight = requests in read pipeline + FIFO entries.
//    req_ready = rst && !load_en && (inflight < RSP_DEPTH); combinational from
//    registered state only (no path from req_valid/rsp_ready).
//  - Accept at edge k: read pipeline carries {data,err}; FIFO write at edge
//    k+READ_LAT; rsp_valid high in the cycle after that edge if FIFO was empty.
//    READ_LAT=1, no backpressure: accept edge k -> rsp_valid from edge k+1.
//  - FIFO: push and pop same cycle legal at any occupancy incl. full (credit
//    rule guarantees no overflow); push ignored never occurs when full.
//    Pop = rsp_valid&rsp_ready. rsp_data/rsp_err stable while valid&!ready.
//  - Ordering: responses strictly in acceptance order.
//  - Errors: req_addr[1:0]!=0 -> rsp_err=1, rsp_data=NOP_INSN.
//    word index = req_addr[ADDR_W-1:2] >= DEPTH_WORDS -> rsp_err=1,
//    rsp_data=NOP_INSN. Misaligned takes precedence; both give one response.
//  - Load: load_en writes mem[load_addr>>2 mod DEPTH_WORDS] at posedge;
//    higher index bits ignored. load_en forces req_ready=0 same cycle;
//    in-flight reads continue and complete. A read issued the cycle after a
//    load to the same word returns the new data.
//  - busy = (inflight != 0). Credit counter width $clog2(RSP_DEPTH+1);
//    incr on accept, decr on pop, both same cycle -> unchanged.
// STRUCTURE
//  - imem_pkg: NOP_INSN = 32'h0000_0013, rsp_t struct {data, err}, error
//    classification function is_bad_addr().
//  - Sub-module: sync_fifo (parameterised width/depth, count output, no reset
//    of storage) for the response queue. Memory and read pipeline inline.
// TESTING
//  - Load mem[0..3]=A0..A3; reqs 0x0,0x4,0x8 back-to-back, rsp_ready=1 ->
//    rsp A0,A1,A2 on consecutive cycles from edge after first accept, err=0.
//  - rsp_ready=0, 6 back-to-back reqs -> exactly RSP_DEPTH=4 accepted,
//    req_ready=0; raise rsp_ready -> 4 ordered rsps, req_ready returns.
//  - req 0x6 -> rsp_err=1, data 0x00000013; req 0x400 (DEPTH 256) -> err=1.
//  - load_en with req_valid=1 -> req_ready=0 that cycle; read of just-loaded
//    word next cycle returns new value.
//  - Assert rst with 3 reqs in flight -> rsp_valid=0, busy=0 immediately;
//    after release no stale responses, mem contents preserved.
//  - READ_LAT=3, random valid/ready 10k cycles vs scoreboard -> order and data
//    match, no loss/duplication, rsp_data stable under stall.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, response type and address classifier
// for the instruction-memory responder.
package imem_pkg;

    localparam int INSN_W = 32;
    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [INSN_W-1:0] data;
        logic              err;
    } rsp_t;

    // Misaligned or beyond the last word -> error response.
    function automatic logic is_bad_addr(
        input logic [63:0] addr,
        input int unsigned depth_words
    );
        return (addr[1:0] != 2'b00) ||
               ((addr >> 2) >= 64'(depth_words));
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response handshake bundle.
// master = fetch side, slave = memory side (req_*, rsp_*).
interface imem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, storage not reset.
// Ports: clk, rst (async low), i_push/i_din, i_pop, o_dout, o_empty, o_full, o_count.
module sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_pop;
    logic          w_push;

    always_comb begin
        o_empty = (r_cnt == '0);
        o_full  = (r_cnt == CW'(DEPTH));
        o_count = r_cnt;
        o_dout  = r_mem[r_rp];
        w_pop   = i_pop && !o_empty;
        // A full FIFO may still accept when the head leaves this cycle.
        w_push  = i_push && (!o_full || w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction memory answering fetch requests in order
// after READ_LAT cycles. Ports: clk, rst, bus (slave), load_*, busy.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 1,
    parameter int RSP_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    imem_responder_if.slave   bus,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int FW    = $bits(rsp_t);

    logic [DATA_W-1:0]  r_mem [DEPTH_WORDS];
    logic [CNT_W-1:0]   r_credit;
    logic [READ_LAT-1:0] r_pv;
    rsp_t [READ_LAT-1:0] r_pd;

    logic       w_bad;
    logic       w_accept;
    logic       w_pop;
    logic       w_empty;
    rsp_t       w_rd;
    rsp_t       w_head;
    logic [FW-1:0] w_dout;
    logic       w_unused_full;
    logic [CNT_W-1:0] w_unused_cnt;
    logic       w_unused_ld;

    always_comb begin
        w_bad       = is_bad_addr(64'(bus.req_addr), DEPTH_WORDS);
        w_rd.err    = w_bad;
        w_rd.data   = w_bad ? NOP_INSN
                            : r_mem[bus.req_addr[IDX_W+1:2]];
        // Credit gate uses registered state plus load_en only.
        bus.req_ready = rst && !load_en &&
                        (r_credit < CNT_W'(RSP_DEPTH));
        w_accept      = bus.req_valid && bus.req_ready;
        w_head        = w_dout;
        bus.rsp_valid = !w_empty;
        w_pop         = bus.rsp_valid && bus.rsp_ready;
        bus.rsp_data  = w_empty ? '0 : w_head.data;
        bus.rsp_err   = w_empty ? 1'b0 : w_head.err;
        busy          = (r_credit != '0);
        w_unused_ld   = ^{load_addr[ADDR_W-1:IDX_W+2], load_addr[1:0]};
    end

    always_ff @(posedge clk) begin
        if (load_en) r_mem[load_addr[IDX_W+1:2]] <= load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv <= '0;
            r_pd <= '0;
        end else begin
            r_pv[0] <= w_accept;
            r_pd[0] <= w_rd;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit <= '0;
        end else begin
            unique case ({w_accept, w_pop})
                2'b10:   r_credit <= r_credit + CNT_W'(1);
                2'b01:   r_credit <= r_credit - CNT_W'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    sync_fifo #(
        .W     (FW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pv[READ_LAT-1]),
        .i_din   (r_pd[READ_LAT-1]),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_full  (w_unused_full),
        .o_count (w_unused_cnt)
    );
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks on a READ_LAT=1 instance and a
// randomized run on a READ_LAT=3 instance, both against a queue model.
module tb_imem_responder;
    import imem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        load_en   = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        busy1;
    logic        busy3;

    imem_responder_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    imem_responder_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    imem_responder #(.READ_LAT(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy1)
    );
    imem_responder #(.READ_LAT(3)) u3 (
        .clk(clk), .rst(rst), .bus(b3), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc1 = 0, n_pop1 = 0, n_acc3 = 0, n_pop3 = 0;

    logic [31:0] mdl_mem [256];
    logic [32:0] q1 [$];
    logic [32:0] q3 [$];
    logic [32:0] hold1, hold3;
    logic stall1 = 1'b0, stall3 = 1'b0;

    logic        v1 = 0, r1 = 1, v3 = 0, r3 = 1;
    logic [31:0] a1 = '0, a3 = '0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {err,data} for a fetch of byte address a, from the model memory.
    function automatic logic [32:0] exp_rsp(logic [31:0] a);
        if (a[1:0] != 2'b00 || a[31:10] != '0) return {1'b1, NOP_INSN};
        return {1'b0, mdl_mem[a[9:2]]};
    endfunction

    task automatic tick();
        logic acc1, pop1, acc3, pop3, sv1, sv3;
        logic [32:0] o1, o3;
        b1.req_valid = v1; b1.req_addr = a1; b1.rsp_ready = r1;
        b3.req_valid = v3; b3.req_addr = a3; b3.rsp_ready = r3;
        #1;
        o1 = {b1.rsp_err, b1.rsp_data};
        o3 = {b3.rsp_err, b3.rsp_data};
        if (rst) begin
            chk("ready1", b1.req_ready, !load_en && q1.size() < 4);
            chk("ready3", b3.req_ready, !load_en && q3.size() < 4);
            chk("busy1", busy1, q1.size() != 0);
            chk("busy3", busy3, q3.size() != 0);
            if (stall1) chk("stall1", {b1.rsp_valid, o1}, {1'b1, hold1});
            if (stall3) chk("stall3", {b3.rsp_valid, o3}, {1'b1, hold3});
            if (b1.rsp_valid) begin
                chk("rspq1", q1.size() != 0, 1);
                if (q1.size() != 0) chk("rsp1", o1, q1[0]);
            end
            if (b3.rsp_valid) begin
                chk("rspq3", q3.size() != 0, 1);
                if (q3.size() != 0) chk("rsp3", o3, q3[0]);
            end
        end
        acc1 = v1 && b1.req_ready; pop1 = b1.rsp_valid && r1;
        acc3 = v3 && b3.req_ready; pop3 = b3.rsp_valid && r3;
        sv1 = b1.rsp_valid && !r1;
        sv3 = b3.rsp_valid && !r3;
        @(posedge clk);
        if (pop1 && q1.size() != 0) void'(q1.pop_front());
        if (pop3 && q3.size() != 0) void'(q3.pop_front());
        if (acc1) q1.push_back(exp_rsp(a1));
        if (acc3) q3.push_back(exp_rsp(a3));
        n_acc1 += int'(acc1); n_pop1 += int'(pop1);
        n_acc3 += int'(acc3); n_pop3 += int'(pop3);
        stall1 = sv1; hold1 = o1;
        stall3 = sv3; hold3 = o3;
        if (load_en) mdl_mem[load_addr[9:2]] = load_data;
        #1;
    endtask

    task automatic rsp1_is(string tag, logic [32:0] e);
        chk(tag, {b1.rsp_valid, b1.rsp_err, b1.rsp_data}, {1'b1, e});
    endtask

    initial begin
        logic [31:0] t;
        int base_a, base_p;
        b1.req_valid = 0; b1.req_addr = '0; b1.rsp_ready = 1;
        b3.req_valid = 0; b3.req_addr = '0; b3.rsp_ready = 1;

        // Reset state
        #12;
        chk("rst_ready1", b1.req_ready, 0);
        chk("rst_valid1", b1.rsp_valid, 0);
        chk("rst_data1", b1.rsp_data, 0);
        chk("rst_err1", b1.rsp_err, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_valid3", b3.rsp_valid, 0);
        chk("rst_busy3", busy3, 0);
        rst = 1'b1;
        #10;

        // Program load; upper index bits are junk and must wrap.
        load_en = 1; v1 = 1; a1 = 32'h0;
        for (int i = 0; i < 256; i++) begin
            t = $urandom();
            load_addr = {t[31:10], 8'(i), t[1:0]};
            load_data = (i < 4) ? 32'hA000_0000 + 32'(i) : $urandom();
            tick();
        end
        chk("load_noacc", n_acc1, 0);
        load_en = 0; v1 = 0;

        // Back-to-back fetches, no backpressure
        r1 = 1;
        v1 = 1; a1 = 32'h0; tick();
        chk("A_lat", b1.rsp_valid, 0);
        a1 = 32'h4; tick();
        rsp1_is("A_rsp0", {1'b0, 32'hA000_0000});
        a1 = 32'h8; tick();
        rsp1_is("A_rsp1", {1'b0, 32'hA000_0001});
        v1 = 0; tick();
        rsp1_is("A_rsp2", {1'b0, 32'hA000_0002});
        tick();

        // Credit limit under backpressure
        base_a = n_acc1; base_p = n_pop1;
        r1 = 0; v1 = 1;
        for (int i = 0; i < 6; i++) begin
            a1 = 32'h10 + 32'(4 * i);
            tick();
        end
        chk("B_acc", n_acc1 - base_a, 4);
        chk("B_rdy0", b1.req_ready, 0);
        v1 = 0; r1 = 1;
        for (int i = 0; i < 20 && q1.size() != 0; i++) tick();
        chk("B_pops", n_pop1 - base_p, 4);
        chk("B_rdy1", b1.req_ready, 1);

        // Error classification
        v1 = 1; a1 = 32'h6; tick();
        a1 = 32'h400; tick();
        rsp1_is("C_mis", {1'b1, NOP_INSN});
        a1 = 32'h3FC; tick();
        rsp1_is("C_oob", {1'b1, NOP_INSN});
        v1 = 0; tick();
        rsp1_is("C_last", {1'b0, mdl_mem[255]});
        tick();

        // Load blocks acceptance; read right after sees new data
        base_a = n_acc1;
        load_en = 1; load_addr = 32'h0001_0020; load_data = 32'hDEAD_BEEF;
        v1 = 1; a1 = 32'h20; tick();
        chk("D_noacc", n_acc1 - base_a, 0);
        load_en = 0; tick();
        chk("D_acc", n_acc1 - base_a, 1);
        v1 = 0; tick();
        rsp1_is("D_new", {1'b0, 32'hDEAD_BEEF});
        tick();

        // Reset with requests in flight
        r1 = 0; v1 = 1;
        a1 = 32'h0; tick(); a1 = 32'h4; tick(); a1 = 32'h8; tick();
        v1 = 0;
        rst = 1'b0;
        #1;
        chk("E_valid", b1.rsp_valid, 0);
        chk("E_busy", busy1, 0);
        chk("E_ready", b1.req_ready, 0);
        chk("E_data", b1.rsp_data, 0);
        q1.delete(); q3.delete(); stall1 = 0; stall3 = 0;
        tick(); tick();
        rst = 1'b1; r1 = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("E_nostale", n_pop1 == n_acc1 - 3, 1);
        v1 = 1; a1 = 32'h4; tick();
        v1 = 0; tick();
        rsp1_is("E_mem", {1'b0, 32'hA000_0001});
        tick();

        // Randomized traffic on the READ_LAT=3 instance
        for (int c = 0; c < 10000; c++) begin
            int k;
            k = $urandom_range(0, 15);
            v3 = 1'($urandom_range(0, 1));
            r3 = ((c / 500) % 2 == 0) ? 1'($urandom_range(0, 1))
                                       : ($urandom_range(0, 7) != 0);
            t = $urandom();
            if (k == 0)      a3 = {22'h0, 8'(t), 2'(t[9:8] | 2'b01)};
            else if (k == 1) a3 = 32'h400 + {t[31:12], 2'b00};
            else             a3 = {22'h0, 8'(t), 2'b00};
            load_en = ($urandom_range(0, 15) == 0);
            load_addr = $urandom();
            load_data = $urandom();
            tick();
        end
        load_en = 0; v3 = 0; r3 = 1;
        for (int i = 0; i < 50 && q3.size() != 0; i++) tick();
        chk("R_drain", q3.size(), 0);
        chk("R_busy", busy3, 0);
        chk("R_count", n_acc3, n_pop3);
        chk("R_traffic", n_acc3 > 1000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
